// File: rtl/hyper_pipe_pkg.sv
// Shared types and helpers for the hyper_pipe_stream block.
// stream_beat_t is the default-width view of one stream beat; the top
// module builds an equivalent struct from its own width parameters.
package hyper_pipe_pkg;

  localparam int DATA_WIDTH_DEF  = 512;
  localparam int EMPTY_WIDTH_DEF = 6;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0]  data;
    logic                       sop;
    logic                       eop;
    logic [EMPTY_WIDTH_DEF-1:0] empty;
  } stream_beat_t;

  // Almost-full threshold that leaves room for every beat that can still
  // arrive during the forward + reverse pipeline round trip.
  function automatic int calc_thresh(input int depth, input int stages);
    return depth - (2 * stages + 1);
  endfunction

endpackage

// File: rtl/hyper_pipe_skid_fifo.sv
// Show-ahead skid FIFO with occupancy count, full/empty flags and a
// one-cycle overflow pulse for a write attempt that finds it full.
// Storage is not reset; only pointers and count are.
module hyper_pipe_skid_fifo
  import hyper_pipe_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_DEF + EMPTY_WIDTH_DEF + 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_valid,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_ready,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CW'(DEPTH));
  assign w_pop      = !o_empty && i_rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push     = i_wr_valid && (!o_full || w_pop);
  assign o_overflow = i_wr_valid && o_full && !w_pop;
  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Beat storage, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/hyper_pipe_stream.sv
// Flow-controlled hyper pipe: a stream beat crosses NUM_STAGES retiming
// registers into a receive-side skid FIFO, while the FIFO almost-full flag
// crosses NUM_STAGES registers back to the sender.
// Optional feature macro: HYPER_PIPE_STREAM_STATS_EN adds beat/packet
// counters and an occupancy high-water mark.
// Legal configuration: NUM_STAGES 1..8, SKID_DEPTH a power of two and at
// least 2*NUM_STAGES+2.
module hyper_pipe_stream
  import hyper_pipe_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int EMPTY_WIDTH = EMPTY_WIDTH_DEF,
  parameter int NUM_STAGES  = 2,
  parameter int SKID_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic [EMPTY_WIDTH-1:0] in_empty,
  output logic                   in_almost_full,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic [EMPTY_WIDTH-1:0] out_empty,
  input  logic                   out_ready,
  output logic                   overflow_err
`ifdef HYPER_PIPE_STREAM_STATS_EN
  ,
  output logic [31:0]                   stat_beats,
  output logic [31:0]                   stat_pkts,
  output logic [$clog2(SKID_DEPTH):0]   stat_max_occ
`endif
);

  localparam int CNT_W  = $clog2(SKID_DEPTH) + 1;
  localparam int THRESH = calc_thresh(SKID_DEPTH, NUM_STAGES);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic                   sop;
    logic                   eop;
    logic [EMPTY_WIDTH-1:0] empty;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  beat_t             w_in_beat;
  beat_t             w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_ovf_pulse;

  logic  w_vld_src  [NUM_STAGES];
  beat_t w_beat_src [NUM_STAGES];
  logic  r_vld_p    [NUM_STAGES];
  beat_t r_beat_p   [NUM_STAGES];

  logic  r_af_raw;
  logic  w_af_src   [NUM_STAGES];
  logic  r_af_p     [NUM_STAGES];

  logic  r_ovf;

  assign w_in_beat = {in_data, in_sop, in_eop, in_empty};

  // Forward chain: valids are reset, payload is left free for retiming.
  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_fwd
    if (s == 0) begin : g_first
      assign w_vld_src[s]  = in_valid;
      assign w_beat_src[s] = w_in_beat;
    end else begin : g_next
      assign w_vld_src[s]  = r_vld_p[s-1];
      assign w_beat_src[s] = r_beat_p[s-1];
    end

    // Stage valid register, cleared on reset.
    always_ff @(posedge clk) begin
      if (!rst_n) r_vld_p[s] <= 1'b0;
      else        r_vld_p[s] <= w_vld_src[s];
    end

    // Stage payload register, never reset.
    always_ff @(posedge clk) begin
      r_beat_p[s] <= w_beat_src[s];
    end
  end

  hyper_pipe_skid_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_valid (r_vld_p[NUM_STAGES-1]),
    .i_wr_data  (r_beat_p[NUM_STAGES-1]),
    .i_rd_ready (out_ready),
    .o_rd_data  (w_head),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_overflow (w_ovf_pulse)
  );

  // Registered almost-full; held high in reset so upstream stays quiet.
  // Full always implies the threshold; it is OR'd in so the flag cannot
  // drop while the FIFO is full whatever the configuration.
  always_ff @(posedge clk) begin
    if (!rst_n) r_af_raw <= 1'b1;
    else        r_af_raw <= (w_count >= CNT_W'(THRESH)) || w_full;
  end

  // Reverse chain carrying almost-full back to the sender.
  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_rev
    if (s == 0) begin : g_first
      assign w_af_src[s] = r_af_raw;
    end else begin : g_next
      assign w_af_src[s] = r_af_p[s-1];
    end

    // Reverse stage register, set on reset.
    always_ff @(posedge clk) begin
      if (!rst_n) r_af_p[s] <= 1'b1;
      else        r_af_p[s] <= w_af_src[s];
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n)           r_ovf <= 1'b0;
    else if (w_ovf_pulse) r_ovf <= 1'b1;
  end

  assign in_almost_full = r_af_p[NUM_STAGES-1];
  assign overflow_err   = r_ovf;
  assign out_valid      = !w_empty;
  assign out_data       = w_head.data;
  assign out_sop        = w_head.sop;
  assign out_eop        = w_head.eop;
  assign out_empty      = w_head.empty;

`ifdef HYPER_PIPE_STREAM_STATS_EN
  logic             w_pop;
  logic [31:0]      r_stat_beats;
  logic [31:0]      r_stat_pkts;
  logic [CNT_W-1:0] r_stat_max;

  assign w_pop = !w_empty && out_ready;

  // Beat/packet counters (wrapping) and occupancy high-water mark.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_beats <= '0;
      r_stat_pkts  <= '0;
      r_stat_max   <= '0;
    end else begin
      if (w_pop)               r_stat_beats <= r_stat_beats + 32'd1;
      if (w_pop && w_head.eop) r_stat_pkts  <= r_stat_pkts + 32'd1;
      if (w_count > r_stat_max) r_stat_max  <= w_count;
    end
  end

  assign stat_beats   = r_stat_beats;
  assign stat_pkts    = r_stat_pkts;
  assign stat_max_occ = r_stat_max;
`endif

endmodule
